// File: rtl/lagarto_plic_target.sv
// Target-side PLIC core: pending/in-service tracking, priority arbitration
// against a threshold, hart notification and claim/complete handshake.
module lagarto_plic_target #(
  parameter int unsigned NUMBER_OF_INTERRUPT_SOURCES = 32,
  parameter int unsigned PRIORITY_WIDTH              = 3,
  parameter int unsigned MXLEN                       = 64
) (
  input  logic                                                  clk_i,
  input  logic                                                  rstn_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_request_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES*PRIORITY_WIDTH-1:0] interrupt_priority_i,
  input  logic [PRIORITY_WIDTH-1:0]                             interrupt_threshold_i,
  input  logic                                                  interrupt_claim_i,
  input  logic                                                  interrupt_complete_i,
  input  logic [MXLEN-1:0]                                      interrupt_complete_id_i,
  output logic                                                  interrupt_notification_o,
  output logic [MXLEN-1:0]                                      interrupt_id_o,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_complete_o
);

  localparam int unsigned N = NUMBER_OF_INTERRUPT_SOURCES;
  localparam int unsigned P = PRIORITY_WIDTH;

  logic [N-1:0]     pending_q;
  logic [N-1:0]     in_service_q;
  logic [P-1:0]     win_prio_c;
  logic [MXLEN-1:0] win_id_c;
  logic [N-1:0]     win_onehot_c;
  logic             eligible_c;
  logic [N-1:0]     claim_mask_c;
  logic [N-1:0]     complete_mask_c;

  // Priority arbiter: strict '>' keeps the lowest ID on ties; prio 0 never wins.
  always_comb begin
    win_prio_c   = '0;
    win_id_c     = '0;
    win_onehot_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pending_q[i] && (interrupt_priority_i[i*P +: P] > win_prio_c)) begin
        win_prio_c   = interrupt_priority_i[i*P +: P];
        win_id_c     = MXLEN'(i + 1);
        win_onehot_c = N'(1) << i;
      end
    end
  end

  // Eligibility against the threshold; equal priority does not qualify.
  assign eligible_c   = (win_prio_c > interrupt_threshold_i);
  assign claim_mask_c = (interrupt_claim_i && eligible_c) ? win_onehot_c : '0;

  // Decode a valid completion: in range and currently in service.
  always_comb begin
    complete_mask_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (interrupt_complete_i && (interrupt_complete_id_i == MXLEN'(i + 1))
          && in_service_q[i]) begin
        complete_mask_c[i] = 1'b1;
      end
    end
  end

  // Pending and in-service state; a new request beats a same-cycle claim.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q    <= (pending_q & ~claim_mask_c) | interrupt_request_i;
      in_service_q <= (in_service_q & ~complete_mask_c) | claim_mask_c;
    end
  end

  // Registered outputs to the hart and the gateways.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      interrupt_notification_o <= 1'b0;
      interrupt_id_o           <= '0;
      interrupt_complete_o     <= '0;
    end else begin
      interrupt_notification_o <= eligible_c;
      interrupt_complete_o     <= complete_mask_c;
      if (interrupt_claim_i) begin
        interrupt_id_o <= eligible_c ? win_id_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_lagarto_plic_target.sv
// Directed bench for lagarto_plic_target with hand-computed expectations.
module tb_lagarto_plic_target;

  localparam int unsigned N     = 32;
  localparam int unsigned P     = 3;
  localparam int unsigned MXLEN = 64;

  logic               clk;
  logic               rstn;
  logic [N-1:0]       req;
  logic [N*P-1:0]     prio;
  logic [P-1:0]       thr;
  logic               claim;
  logic               cmpl;
  logic [MXLEN-1:0]   cmpl_id;
  logic               notif;
  logic [MXLEN-1:0]   id;
  logic [N-1:0]       cmpl_o;

  int n_tests = 0;
  int n_fail  = 0;

  lagarto_plic_target #(
    .NUMBER_OF_INTERRUPT_SOURCES(N),
    .PRIORITY_WIDTH(P),
    .MXLEN(MXLEN)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .interrupt_request_i(req),
    .interrupt_priority_i(prio),
    .interrupt_threshold_i(thr),
    .interrupt_claim_i(claim),
    .interrupt_complete_i(cmpl),
    .interrupt_complete_id_i(cmpl_id),
    .interrupt_notification_o(notif),
    .interrupt_id_o(id),
    .interrupt_complete_o(cmpl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int idx, input int val);
    prio[idx*P +: P] = P'(val);
  endtask

  task automatic do_claim(input string tag, input logic [63:0] exp_id);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check(tag, id, exp_id);
  endtask

  task automatic do_complete(input string tag, input logic [63:0] cid, input logic [63:0] exp_mask);
    cmpl    = 1'b1;
    cmpl_id = MXLEN'(cid);
    tick();
    cmpl    = 1'b0;
    cmpl_id = '0;
    check({tag, "_pulse"}, 64'(cmpl_o), exp_mask);
    tick();
    check({tag, "_after"}, 64'(cmpl_o), 64'd0);
  endtask

  initial begin
    rstn    = 1'b0;
    req     = '0;
    prio    = '0;
    thr     = '0;
    claim   = 1'b0;
    cmpl    = 1'b0;
    cmpl_id = '0;

    // Reset: request during reset must be ignored.
    set_prio(4, 3);
    req[4] = 1'b1;
    tick();
    tick();
    check("rst_notif", 64'(notif), 64'd0);
    check("rst_id", id, 64'd0);
    check("rst_cmpl", 64'(cmpl_o), 64'd0);
    req  = '0;
    rstn = 1'b1;
    tick();
    tick();
    check("post_rst_notif", 64'(notif), 64'd0);

    // Request latency and first claim.
    req[4] = 1'b1;
    tick();
    req = '0;
    check("req_e_notif", 64'(notif), 64'd0);
    tick();
    check("req_e1_notif", 64'(notif), 64'd1);
    do_claim("claim5", 64'd5);
    check("claim_c_notif", 64'(notif), 64'd1);
    tick();
    check("claim_c1_notif", 64'(notif), 64'd0);

    // Arbitration: highest prio first, then lowest ID on ties.
    set_prio(2, 5);
    set_prio(7, 5);
    set_prio(9, 6);
    req[2] = 1'b1;
    req[7] = 1'b1;
    req[9] = 1'b1;
    tick();
    req = '0;
    tick();
    check("arb_notif", 64'(notif), 64'd1);
    do_claim("arb_1", 64'd10);
    do_claim("arb_2", 64'd3);
    do_claim("arb_3", 64'd8);
    do_claim("arb_4", 64'd0);
    tick();
    check("arb_empty_notif", 64'(notif), 64'd0);

    // Completion: valid, repeated, ID 0, out of range.
    do_complete("cmp5", 64'd5, 64'h10);
    do_complete("cmp5_again", 64'd5, 64'd0);
    do_complete("cmp0", 64'd0, 64'd0);
    do_complete("cmp33", 64'd33, 64'd0);
    do_complete("cmp10", 64'd10, 64'h200);

    // Threshold: equal does not qualify, lowering it does.
    set_prio(11, 2);
    thr = 3'd2;
    req[11] = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
    check("thr_eq_notif", 64'(notif), 64'd0);
    do_claim("thr_eq_claim", 64'd0);
    thr = 3'd1;
    tick();
    check("thr_low_notif", 64'(notif), 64'd1);
    do_claim("thr_low_claim", 64'd12);
    thr = 3'd0;

    // Simultaneous claim and complete, with a request at the claim edge.
    req[4] = 1'b1;
    tick();
    req = '0;
    do_claim("re_claim5", 64'd5);
    req[2] = 1'b1;
    tick();
    req = '0;
    claim   = 1'b1;
    cmpl    = 1'b1;
    cmpl_id = MXLEN'(5);
    req[2]  = 1'b1;
    tick();
    claim   = 1'b0;
    cmpl    = 1'b0;
    cmpl_id = '0;
    req     = '0;
    check("sim_id", id, 64'd3);
    check("sim_cmpl", 64'(cmpl_o), 64'h10);
    do_claim("sim_reclaim", 64'd3);
    check("sim_cmpl_done", 64'(cmpl_o), 64'd0);

    // Reset between claim and complete drops in-service state.
    req[4] = 1'b1;
    tick();
    req = '0;
    do_claim("pre_rst_claim", 64'd5);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_id", id, 64'd0);
    check("midrst_notif", 64'(notif), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    do_complete("midrst_cmp5", 64'd5, 64'd0);
    do_claim("midrst_claim", 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
